octal_to_binary_encoder: RTL and testbench

- Registered 8-to-3 encoder. It converts an eight-line (octal) select vector `s` into a 3-bit binary index `y`.
- Status flags report valid input (at least one bit set) and non-one-hot input (more than one bit set).
- Used wherever a one-hot octal select must be reduced to a binary code, for example mux select or state index.
- Multi-hot input is resolved by fixed priority, so `y` is always defined.

---
 rtl/octal_enc_pkg.sv | 12 +
 rtl/prio_onehot_enc.sv | 37 +++
 rtl/octal_to_binary_encoder.sv | 57 +++++
 tb/tb_octal_to_binary_encoder.sv | 100 ++++++++++
 4 files changed

// File: rtl/octal_enc_pkg.sv
// Shared types and constants for the octal (8-to-3) encoder.
//   ENC_IN_W  : number of select lines at the default configuration
//   ENC_OUT_W : width of the encoded index at the default configuration
//   enc_sel_t : select-vector type
//   enc_idx_t : encoded-index type
package octal_enc_pkg;
  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = $clog2(ENC_IN_W);

  typedef logic [ENC_IN_W-1:0]  enc_sel_t;
  typedef logic [ENC_OUT_W-1:0] enc_idx_t;
endpackage

// File: rtl/prio_onehot_enc.sv
// Combinational priority encoder for a nominally one-hot select vector.
//   s     (in)  : select lines
//   idx   (out) : index of the winning set bit (0 when s is zero)
//   any   (out) : at least one bit of s is set
//   multi (out) : two or more bits of s are set
// PRIO_HIGH picks the winner on multi-hot input: 1 = highest index, 0 = lowest.
module prio_onehot_enc
  import octal_enc_pkg::*;
#(
  parameter int IN_W      = ENC_IN_W,
  parameter int OUT_W     = $clog2(IN_W),
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [IN_W-1:0]  s,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Later iterations overwrite earlier ones, so the scan direction sets the
  // priority: an ascending scan leaves the highest set bit, descending the lowest.
  always_comb begin
    idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < IN_W; i++)
        if (s[i]) idx = OUT_W'(i);
    end else begin
      for (int i = IN_W - 1; i >= 0; i--)
        if (s[i]) idx = OUT_W'(i);
    end
  end

  assign any   = |s;
  // Clearing the lowest set bit leaves something only when two or more were set.
  assign multi = |(s & (s - IN_W'(1)));

endmodule

// File: rtl/octal_to_binary_encoder.sv
// Registered 8-to-3 (octal) encoder with valid / non-one-hot status.
//   clk   (in)  : clock, rising edge
//   rst   (in)  : synchronous active-high reset, clears all outputs
//   s     (in)  : select lines, nominally one-hot
//   y     (out) : registered index of the winning set bit
//   valid (out) : registered, s had at least one bit set
//   err   (out) : registered, s had two or more bits set
// One cycle of latency; a new s is accepted every cycle.
module octal_to_binary_encoder
  import octal_enc_pkg::*;
#(
  parameter int IN_W      = ENC_IN_W,
  parameter int OUT_W     = $clog2(IN_W),
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             err
);

  logic [OUT_W-1:0] y_d, y_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;

  prio_onehot_enc #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc (
    .s     (s),
    .idx   (y_d),
    .any   (valid_d),
    .multi (err_d)
  );

  // All three outputs share one register stage so they stay aligned to the
  // same sampled s.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_octal_to_binary_encoder.sv
module tb_octal_to_binary_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s   = 8'h00;
  logic [2:0] yh, yl;
  logic       vh, vl, eh, el;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  octal_to_binary_encoder #(.IN_W(8), .PRIO_HIGH(1'b1)) dut_h (
    .clk(clk), .rst(rst), .s(s), .y(yh), .valid(vh), .err(eh)
  );

  octal_to_binary_encoder #(.IN_W(8), .PRIO_HIGH(1'b0)) dut_l (
    .clk(clk), .rst(rst), .s(s), .y(yl), .valid(vl), .err(el)
  );

  // Advance one edge; outputs then reflect the s/rst driven before it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_h(input string tag, input logic [2:0] y_e, input logic v_e, input logic e_e);
    checks++;
    assert ({yh, vh, eh} === {y_e, v_e, e_e}) else begin
      errors++;
      $error("FAIL %s(high) got y=%0d valid=%b err=%b want y=%0d valid=%b err=%b",
             tag, yh, vh, eh, y_e, v_e, e_e);
    end
  endtask

  task automatic chk_l(input string tag, input logic [2:0] y_e, input logic v_e, input logic e_e);
    checks++;
    assert ({yl, vl, el} === {y_e, v_e, e_e}) else begin
      errors++;
      $error("FAIL %s(low) got y=%0d valid=%b err=%b want y=%0d valid=%b err=%b",
             tag, yl, vl, el, y_e, v_e, e_e);
    end
  endtask

  initial begin
    // Reset held two cycles with s=10000000
    rst = 1'b1; s = 8'b1000_0000;
    step(); chk_h("rst0", 3'd0, 1'b0, 1'b0); chk_l("rst0", 3'd0, 1'b0, 1'b0);
    step(); chk_h("rst1", 3'd0, 1'b0, 1'b0); chk_l("rst1", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_h("rel", 3'd7, 1'b1, 1'b0); chk_l("rel", 3'd7, 1'b1, 1'b0);

    // One-hot sweep
    for (int k = 0; k < 8; k++) begin
      s = 8'b1 << k;
      step();
      chk_h("sweep", 3'(k), 1'b1, 1'b0);
      chk_l("sweep", 3'(k), 1'b1, 1'b0);
    end

    // Hold steady input: no toggling
    step(); chk_h("hold", 3'd7, 1'b1, 1'b0);

    // Zero input, then bit 0 (same y, different valid)
    s = 8'b0000_0000;
    step(); chk_h("zero", 3'd0, 1'b0, 1'b0); chk_l("zero", 3'd0, 1'b0, 1'b0);
    s = 8'b0000_0001;
    step(); chk_h("bit0", 3'd0, 1'b1, 1'b0); chk_l("bit0", 3'd0, 1'b1, 1'b0);

    // Multi-hot priority resolution
    s = 8'b0010_0100;
    step(); chk_h("mh24", 3'd5, 1'b1, 1'b1); chk_l("mh24", 3'd2, 1'b1, 1'b1);
    s = 8'b1111_1111;
    step(); chk_h("mhff", 3'd7, 1'b1, 1'b1); chk_l("mhff", 3'd0, 1'b1, 1'b1);
    s = 8'b1100_0000;
    step(); chk_h("mhc0", 3'd7, 1'b1, 1'b1); chk_l("mhc0", 3'd6, 1'b1, 1'b1);
    s = 8'b1000_0001;
    step(); chk_h("mh81", 3'd7, 1'b1, 1'b1); chk_l("mh81", 3'd0, 1'b1, 1'b1);
    s = 8'b0001_1000;
    step(); chk_h("mh18", 3'd4, 1'b1, 1'b1); chk_l("mh18", 3'd3, 1'b1, 1'b1);

    // Mid-stream reset during a sweep
    s = 8'b0000_0100; step(); chk_h("ms2", 3'd2, 1'b1, 1'b0);
    s = 8'b0000_1000; step(); chk_h("ms3", 3'd3, 1'b1, 1'b0);
    s = 8'b0001_0000; rst = 1'b1;
    step(); chk_h("msrst", 3'd0, 1'b0, 1'b0); chk_l("msrst", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_h("ms4", 3'd4, 1'b1, 1'b0); chk_l("ms4", 3'd4, 1'b1, 1'b0);
    s = 8'b0010_0000;
    step(); chk_h("ms5", 3'd5, 1'b1, 1'b0); chk_l("ms5", 3'd5, 1'b1, 1'b0);

    // Reset with multi-hot input must clear err as well
    s = 8'b1111_1111; rst = 1'b1;
    step(); chk_h("rstmh", 3'd0, 1'b0, 1'b0); chk_l("rstmh", 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_h("postmh", 3'd7, 1'b1, 1'b1); chk_l("postmh", 3'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
